clkgen_multi: RTL

Synthesisable multi-channel programmable clock/pulse generator, successor to the behavioural period/duty/phase clock task used in the delay benches. Each of NUM_CH channels produces a divided waveform from `clk` with run-time programmable period, high time and start phase, all in `clk` cycles. Sits beside the DUT in benches and in FPGA test harnesses as a stimulus source for derived strobes and gated clocks.

---
 rtl/clkgen_pkg.sv | 20 ++
 rtl/clkgen_if.sv | 38 +++
 rtl/clkgen_multi_chan.sv | 194 +++++++++++++++++++
 rtl/clkgen_multi.sv | 80 ++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_multi shared types: channel state encoding and config bundle.
// Optional feature macro used by this block: CLKGEN_SHADOW_EN.
package clkgen_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        PHASE,
        HIGH,
        LOW
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
        logic [CNT_W_DEF-1:0] phase;
    } cfg_t;

endpackage

// File: rtl/clkgen_if.sv
// Configuration write port of clkgen_multi (valid/ready plus error pulse).
// Optional feature macro used by this block: CLKGEN_SHADOW_EN.
interface clkgen_if
    import clkgen_pkg::*;
#(
    parameter int CH_W  = 2,
    parameter int CNT_W = CNT_W_DEF
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_high,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_high,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clkgen_multi_chan.sv
// One clkgen channel: IDLE/PHASE/HIGH/LOW FSM, cycle counter, config regs.
// CLKGEN_SHADOW_EN adds a shadow config adopted at the next HIGH entry.
module clkgen_chan
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_phase,
`ifdef CLKGEN_SHADOW_EN
    output logic             o_pending,
`endif
    output logic             o_clk,
    output logic             o_cyc
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    state_t           r_state;
    state_t           w_nstate;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_ncnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_ph;
    logic [CNT_W-1:0] w_per;
    logic [CNT_W-1:0] w_hi;
    logic [CNT_W-1:0] w_ph;
    logic             w_now;
    logic             w_enter;
    logic             r_entry;
    logic             r_clk;
    logic             r_cyc;

`ifdef CLKGEN_SHADOW_EN
    logic [CNT_W-1:0] r_sh_per;
    logic [CNT_W-1:0] r_sh_hi;
    logic [CNT_W-1:0] r_sh_ph;
    logic             r_pend;
    logic             w_adopt;

    // Stopped or still-phasing channels take a write at once.
    assign w_now = i_wr && (r_state == IDLE || r_state == PHASE);
    assign o_pending = r_pend;
`else
    assign w_now = i_wr;
`endif

    // Next state and counter; a same-cycle write is the config used.
    always_comb begin
        w_per = w_now ? i_period : r_per;
        w_hi  = w_now ? i_high   : r_hi;
        w_ph  = w_now ? i_phase  : r_ph;
        w_nstate = r_state;
        w_ncnt   = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;
        w_enter  = 1'b0;
`ifdef CLKGEN_SHADOW_EN
        w_adopt  = 1'b0;
`endif
        if (!i_en || w_per == '0) begin
            w_nstate = IDLE;
            w_ncnt   = '0;
        end else if (r_state == IDLE || w_now) begin
            w_ncnt = C_ONE;
            if (w_ph != '0) begin
                w_nstate = PHASE;
            end else if (w_hi == '0) begin
                w_nstate = LOW;
            end else begin
                w_nstate = HIGH;
                w_enter  = 1'b1;
            end
        end else begin
            unique case (r_state)
                PHASE: begin
                    if (r_cnt == w_ph) begin
                        w_ncnt = C_ONE;
                        if (w_hi == '0) begin
                            w_nstate = LOW;
                        end else begin
                            w_nstate = HIGH;
                            w_enter  = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (w_hi >= w_per) begin
                        w_ncnt = r_cnt;
`ifdef CLKGEN_SHADOW_EN
                        if (r_pend) begin
                            w_adopt = 1'b1;
                            w_ncnt  = C_ONE;
                            if (r_sh_per == '0) begin
                                w_nstate = IDLE;
                            end else if (r_sh_hi == '0) begin
                                w_nstate = LOW;
                            end
                        end
`endif
                    end else if (r_cnt == w_hi) begin
                        w_nstate = LOW;
                        w_ncnt   = C_ONE;
                    end
                end
                LOW: begin
                    if (r_cnt == w_per - w_hi) begin
                        w_ncnt = C_ONE;
`ifdef CLKGEN_SHADOW_EN
                        if (r_pend) begin
                            w_adopt = 1'b1;
                            if (r_sh_per == '0) begin
                                w_nstate = IDLE;
                            end else if (r_sh_hi == '0) begin
                                w_nstate = LOW;
                            end else begin
                                w_nstate = HIGH;
                                w_enter  = 1'b1;
                            end
                        end else
`endif
                        if (w_hi == '0) begin
                            w_nstate = LOW;
                        end else begin
                            w_nstate = HIGH;
                            w_enter  = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
`ifdef CLKGEN_SHADOW_EN
        if (r_pend && w_nstate == IDLE) begin
            w_adopt = 1'b1;
        end
`endif
    end

    // State, counter, config and the registered output pair.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_hi    <= '0;
            r_ph    <= '0;
            r_entry <= 1'b0;
            r_clk   <= 1'b0;
            r_cyc   <= 1'b0;
`ifdef CLKGEN_SHADOW_EN
            r_sh_per <= '0;
            r_sh_hi  <= '0;
            r_sh_ph  <= '0;
            r_pend   <= 1'b0;
`endif
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_entry <= w_enter;
            r_clk   <= (r_state == HIGH);
            r_cyc   <= r_entry;
            if (w_now) begin
                r_per <= i_period;
                r_hi  <= i_high;
                r_ph  <= i_phase;
            end
`ifdef CLKGEN_SHADOW_EN
            else if (i_wr) begin
                r_sh_per <= i_period;
                r_sh_hi  <= i_high;
                r_sh_ph  <= i_phase;
                r_pend   <= 1'b1;
            end
            if (w_adopt) begin
                r_per  <= r_sh_per;
                r_hi   <= r_sh_hi;
                r_ph   <= r_sh_ph;
                r_pend <= 1'b0;
            end
`endif
        end
    end

    assign o_clk = r_clk;
    assign o_cyc = r_cyc;

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock/pulse generator top: config decode.
// Optional feature macro: CLKGEN_SHADOW_EN (shadowed config writes).
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    clkgen_if.slave           cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cyc_start
);

    logic [CH_W-1:0]   w_ch;
    logic [NUM_CH-1:0] w_wr;
    logic              w_bad;
    logic              w_ready;
    logic              w_acc;
    logic              r_err;
`ifdef CLKGEN_SHADOW_EN
    logic [NUM_CH-1:0] w_pend;
`endif

    assign w_ch = cfg.cfg_ch;

    // Channel select decode, out-of-range detect and write accept.
    always_comb begin
        w_wr    = '0;
        w_bad   = 1'b1;
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(w_ch) == i) begin
                w_bad = 1'b0;
`ifdef CLKGEN_SHADOW_EN
                w_ready = ~w_pend[i];
`endif
            end
        end
        w_acc = cfg.cfg_valid && w_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr[i] = w_acc && (int'(w_ch) == i);
        end
    end

    // Dropped out-of-range write reported one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_acc && w_bad;
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign cfg.cfg_err   = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkgen_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_en     (en[g]),
            .i_wr     (w_wr[g]),
            .i_period (cfg.cfg_period),
            .i_high   (cfg.cfg_high),
            .i_phase  (cfg.cfg_phase),
`ifdef CLKGEN_SHADOW_EN
            .o_pending(w_pend[g]),
`endif
            .o_clk    (clk_out[g]),
            .o_cyc    (cyc_start[g])
        );
    end

endmodule
